// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between the PC register and decode.
// One outstanding 64-bit read; redirects discard stale or in-flight words.
module instr_fetch #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               flush,
  output logic               pc_latch,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q;
  logic                 req_q;
  logic                 drop_q;
  logic                 valid_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W-1:0]    ipc_q;
  logic [INSTR_W-1:0]   instr_q;
  logic [ADDR_W-1:0]    addr_d;

  assign addr_d = pc_in & ~ADDR_W'(7);

  // PC advances on the same edge the word is captured
  assign pc_latch = (state_q == FETCH) & mem_ack
                  & ~drop_q & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      ipc_q   <= '0;
      instr_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          addr_q  <= addr_d;
          req_q   <= 1'b1;
          drop_q  <= 1'b0;
          state_q <= FETCH;
        end
        FETCH: begin
          if (mem_ack) begin
            req_q <= 1'b0;
            if (drop_q || flush) begin
              drop_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              instr_q <= mem_rdata;
              ipc_q   <= addr_q;
              valid_q <= 1'b1;
              state_q <= FULL;
            end
          end else if (flush) begin
            // transaction cannot be aborted; discard its data later
            drop_q <= 1'b1;
          end
        end
        FULL: begin
          if (flush) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end else if (instr_ready) begin
            valid_q <= 1'b0;
            addr_q  <= addr_d;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized run against
// an instruction-stream model (PC and memory modelled in the bench).
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        flush;
  logic        pc_latch;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [63:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int tests = 0;
  int fails = 0;

  int          mem_lat;
  int          wcnt;
  logic        fixed_data;
  logic [31:0] flush_tgt;

  logic        s_latch, s_ack, s_req;
  logic        s_valid, s_ready, s_flush;
  logic [31:0] s_pc;
  logic [63:0] s_out;

  localparam logic [63:0] FIXED = 64'h1111_2222_3333_4444;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .flush       (flush),
    .pc_latch    (pc_latch),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  function automatic logic [63:0] word(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a};
  endfunction

  // One clock cycle: memory responds, outputs sampled at negedge,
  // then the bench PC and memory wait counter update after the edge.
  task automatic cyc();
    mem_ack = mem_req && (wcnt >= mem_lat);
    if (mem_ack)
      mem_rdata = fixed_data ? FIXED : word(mem_addr);
    else
      mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    s_latch = pc_latch;
    s_ack   = mem_ack;
    s_req   = mem_req;
    s_valid = instr_valid;
    s_ready = instr_ready;
    s_flush = flush;
    s_pc    = instr_pc;
    s_out   = instr_out;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (flush) pc_in = flush_tgt;
      else if (s_latch) pc_in = pc_in + 32'd8;
    end
    if (!s_req || s_ack) wcnt = 0;
    else wcnt = wcnt + 1;
  endtask

  task automatic do_reset(input logic [31:0] pc, input logic rdy);
    rst = 1'b1;
    flush = 1'b0;
    flush_tgt = '0;
    instr_ready = rdy;
    pc_in = pc;
    wcnt = 0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mem_lat = 0;
    fixed_data = 1'b1;
    do_reset(32'h0, 1'b1);
    tests++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl req=%b valid=%b want 0 0",
               mem_req, instr_valid);
    end
    tests++;
    if (mem_addr !== 32'h0 || instr_pc !== 32'h0
        || instr_out !== 64'h0) begin
      fails++;
      $display("FAIL reset_data addr=%h pc=%h out=%h want 0",
               mem_addr, instr_pc, instr_out);
    end
    tests++;
    if (pc_latch !== 1'b0) begin
      fails++;
      $display("FAIL reset_latch got %b want 0", pc_latch);
    end
  endtask

  task automatic test_basic();
    mem_lat = 0;
    fixed_data = 1'b1;
    do_reset(32'h0, 1'b1);
    cyc();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'(8 * k)) begin
        fails++;
        $display("FAIL basic_req%0d req=%b addr=%h want 1 %h",
                 k, mem_req, mem_addr, 32'(8 * k));
      end
      cyc();
      tests++;
      if (s_latch !== 1'b1 || s_ack !== 1'b1) begin
        fails++;
        $display("FAIL basic_latch%0d latch=%b ack=%b want 1 1",
                 k, s_latch, s_ack);
      end
      tests++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(8 * k)
          || instr_out !== FIXED) begin
        fails++;
        $display("FAIL basic_out%0d v=%b pc=%h out=%h want 1 %h %h",
                 k, instr_valid, instr_pc, instr_out,
                 32'(8 * k), FIXED);
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    mem_lat = 0;
    fixed_data = 1'b0;
    do_reset(32'h0, 1'b0);
    cyc();
    cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      tests++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0
          || instr_out !== word(32'h0)) begin
        fails++;
        $display("FAIL bp_hold%0d v=%b pc=%h out=%h want 1 0 %h",
                 k, instr_valid, instr_pc, instr_out, word(32'h0));
      end
      tests++;
      if (s_req !== 1'b0 || s_latch !== 1'b0) begin
        fails++;
        $display("FAIL bp_idle%0d req=%b latch=%b want 0 0",
                 k, s_req, s_latch);
      end
    end
    instr_ready = 1'b1;
    cyc();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8
        || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release req=%b addr=%h v=%b want 1 8 0",
               mem_req, mem_addr, instr_valid);
    end
  endtask

  task automatic test_slow_mem();
    mem_lat = 4;
    fixed_data = 1'b0;
    do_reset(32'h8, 1'b1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      cyc();
      tests++;
      if (s_latch !== 1'b0 || mem_req !== 1'b1
          || mem_addr !== 32'h8) begin
        fails++;
        $display("FAIL slow_wait%0d latch=%b req=%b addr=%h want 0 1 8",
                 k, s_latch, mem_req, mem_addr);
      end
    end
    cyc();
    tests++;
    if (s_latch !== 1'b1 || instr_valid !== 1'b1
        || instr_pc !== 32'h8 || instr_out !== word(32'h8)) begin
      fails++;
      $display("FAIL slow_ack latch=%b v=%b pc=%h out=%h want 1 1 8 %h",
               s_latch, instr_valid, instr_pc, instr_out, word(32'h8));
    end
  endtask

  task automatic test_flush_fetch();
    mem_lat = 2;
    fixed_data = 1'b0;
    do_reset(32'h0, 1'b1);
    cyc();
    flush = 1'b1;
    flush_tgt = 32'h17;
    cyc();
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      tests++;
      if (s_latch !== 1'b0 || instr_valid !== 1'b0) begin
        fails++;
        $display("FAIL flf_drop%0d latch=%b v=%b want 0 0",
                 k, s_latch, instr_valid);
      end
    end
    tests++;
    if (s_ack !== 1'b1 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL flf_idle ack=%b req=%b want 1 0", s_ack, mem_req);
    end
    cyc();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10
        || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL flf_restart req=%b addr=%h v=%b want 1 10 0",
               mem_req, mem_addr, instr_valid);
    end
  endtask

  task automatic test_flush_full();
    mem_lat = 0;
    fixed_data = 1'b0;
    do_reset(32'h0, 1'b0);
    cyc();
    cyc();
    instr_ready = 1'b1;
    flush = 1'b1;
    flush_tgt = 32'h40;
    cyc();
    flush = 1'b0;
    tests++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL flfull_drop v=%b req=%b want 0 0",
               instr_valid, mem_req);
    end
    cyc();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      fails++;
      $display("FAIL flfull_target req=%b addr=%h want 1 40",
               mem_req, mem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    mem_lat = 0;
    fixed_data = 1'b0;
    do_reset(32'h100, 1'b0);
    cyc();
    cyc();
    mem_lat = 100;
    instr_ready = 1'b1;
    cyc();
    cyc();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h108
        || instr_pc !== 32'h100) begin
      fails++;
      $display("FAIL rmf_pre req=%b addr=%h pc=%h want 1 108 100",
               mem_req, mem_addr, instr_pc);
    end
    rst = 1'b1;
    cyc();
    tests++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0
        || instr_pc !== 32'h0 || mem_addr !== 32'h0) begin
      fails++;
      $display("FAIL rmf_clear req=%b v=%b pc=%h addr=%h want 0 0 0 0",
               mem_req, instr_valid, instr_pc, mem_addr);
    end
    rst = 1'b0;
    mem_lat = 0;
    cyc();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h108) begin
      fails++;
      $display("FAIL rmf_restart req=%b addr=%h want 1 108",
               mem_req, mem_addr);
    end
  endtask

  task automatic test_wrap();
    mem_lat = 0;
    fixed_data = 1'b0;
    do_reset(32'hFFFF_FFF8, 1'b1);
    cyc();
    cyc();
    tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFF8
        || instr_out !== word(32'hFFFF_FFF8)) begin
      fails++;
      $display("FAIL wrap_top v=%b pc=%h out=%h want 1 fffffff8 %h",
               instr_valid, instr_pc, instr_out, word(32'hFFFF_FFF8));
    end
    cyc();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      fails++;
      $display("FAIL wrap_zero req=%b addr=%h want 1 0",
               mem_req, mem_addr);
    end
  endtask

  // Program-order model: each delivered word must be the next
  // sequential address, restarting at the aligned branch target.
  task automatic test_random();
    logic [31:0] exp_next;
    int          delivered;
    int          bad;
    delivered = 0;
    bad = 0;
    fixed_data = 1'b0;
    mem_lat = 0;
    do_reset($urandom, 1'b1);
    exp_next = pc_in & ~32'h7;
    for (int c = 0; c < 3000; c++) begin
      mem_lat = $urandom_range(0, 3);
      instr_ready = ($urandom_range(0, 3) != 0);
      flush = (mem_req || instr_valid) && ($urandom_range(0, 19) == 0);
      flush_tgt = $urandom;
      cyc();
      if (s_latch && !s_ack && bad < 5) begin
        bad++;
        tests++;
        fails++;
        $display("FAIL rnd_latch cycle %0d latch=1 without ack", c);
      end
      if (s_valid && s_ready && !s_flush) begin
        delivered++;
        tests++;
        if (s_pc !== exp_next || s_out !== word(exp_next)) begin
          fails++;
          $display("FAIL rnd_stream cycle %0d pc=%h out=%h want %h %h",
                   c, s_pc, s_out, exp_next, word(exp_next));
        end
        exp_next = exp_next + 32'd8;
      end
      if (s_flush) exp_next = flush_tgt & ~32'h7;
    end
    flush = 1'b0;
    tests++;
    if (delivered < 200) begin
      fails++;
      $display("FAIL rnd_progress delivered=%0d want >=200", delivered);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    flush_tgt = '0;
    pc_in = '0;
    instr_ready = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    mem_lat = 0;
    wcnt = 0;
    fixed_data = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_slow_mem();
    test_flush_fetch();
    test_flush_full();
    test_reset_mid_fetch();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
